la_clkout: RTL and testbench
============================

Name: la_clkout

Overview:
Core-to-pad clock output generator. It is the transmit-direction counterpart of the crystal/clock input cell. It derives a programmable divided clock from the core clock and drives it, with an output enable, towards a pad driver. Start and stop are glitch-free: the output never emits a runt high or low phase, and it always parks low.

Parameters:
DIVW, 8, width of the divide control; half-period length = div+1 core cycles.

Ports:
clk      input   1     core clock; all logic on rising edge
reset    input   1     synchronous, active-high reset
en       input   1     run request; level-sensitive
div      input   DIVW  half-period minus one; sampled only at period start
clkout   output  1     divided clock to pad driver; registered
oe       output  1     pad output enable; registered
busy     output  1     1 whenever state != IDLE; registered
tick     output  1     1-cycle pulse in the cycle clkout first reads 1 of each period

Behaviour:
- Reset: at the rising edge with reset=1, state=IDLE, clkout=0, oe=0, busy=0, tick=0, cnt=0, divq=0. Reset overrides all other inputs, including mid-period.
- Internal registers:
  - cnt, DIVW bits: phase counter.
  - divq, DIVW bits: latched divide value.
- States: IDLE, PRE, HIGH, LOW.
- IDLE: clkout=0, oe=0, busy=0.
  - en=1 sampled -> PRE.
- PRE: oe=1, clkout=0, busy=1. Gives the pad driver one cycle of settle time before the first edge.
  - en=1 -> HIGH: clkout=1, tick=1, divq<=div, cnt<=0.
  - en=0 -> IDLE: oe=0. No clkout edge is ever emitted.
- HIGH: clkout=1, cnt increments each cycle.
  - When cnt==divq -> LOW: clkout=0, cnt<=0.
  - en is ignored here; the high phase always completes.
- LOW: clkout=0, cnt increments each cycle.
  - When cnt==divq and en=1 -> HIGH: clkout=1, tick=1, divq<=div, cnt<=0.
  - When cnt==divq and en=0 -> IDLE: oe=0, busy=0.
  - en is ignored before terminal count.
- Timing:
  - High and low phases are each exactly divq+1 cycles; period = 2*(divq+1). div=0 gives clk/2 at 50% duty.
  - Max div=2^DIVW-1 gives period 2^(DIVW+1) cycles; the counter never wraps.
- Latency: en first sampled 1 at edge k -> oe=1 after edge k, clkout=1 and tick=1 after edge k+1.
- div changes:
  - Changes mid-period have no effect on the current period.
  - A new value is captured only on entry to HIGH, so the first period using it is fully formed.
- Stop: en deasserted at any time -> the current period finishes (high and low phases complete). clkout is 0 and oe drops in the same cycle the state returns to IDLE. oe is never 0 while clkout is 1.
- Back-to-back: en held 1 continuously -> no idle gap between periods, no PRE between periods.
- en glitch: a 1-cycle en pulse in IDLE -> one PRE cycle with oe=1, then IDLE. clkout stays 0.
- tick: high only in HIGH-entry cycles; never asserted in PRE, LOW, or IDLE.

Test Plan:
1. reset=1 for 2 cycles, en=1, div=0 -> oe=1 at cycle 1, then clkout=1,0,1,0…; period 2; tick on every clkout rise; busy=1.
2. div=3, en=1 for 20 cycles then 0 -> clkout high 4 / low 4. The last period completes, then clkout=0, oe=0, busy=0 in the same cycle. No phase shorter than 4.
3. div=2 running, div set to 5 in the middle of a high phase -> the current period stays 3/3; the next period is 6/6; tick marks each start.
4. 1-cycle en pulse from IDLE -> exactly 1 cycle oe=1, busy=1. clkout never 1, tick never 1.
5. div=4 running, reset=1 asserted during the 2nd high cycle -> next edge clkout=0, oe=0, busy=0, state IDLE. With en=1 and reset released, the restart follows the PRE->HIGH latency.
6. div=255 (DIVW=8), en held -> period 512 cycles exactly, no counter wrap, 50% duty over 3 periods.

Source files
------------

// File: rtl/la_clkout.sv
// Core-to-pad divided clock generator with glitch-free start/stop and pad output enable.
// Output always parks low; every emitted phase is exactly div+1 core cycles long.
module la_clkout #(
   parameter int DIVW = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [DIVW-1:0] div,
   output logic            clkout,
   output logic            oe,
   output logic            busy,
   output logic            tick
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_nextState;
   logic [DIVW-1:0] r_cnt;
   logic [DIVW-1:0] r_divq;
   logic [DIVW-1:0] w_nextCnt;
   logic [DIVW-1:0] w_nextDivq;
   logic            w_terminal;
   logic            w_enterHigh;
   logic            r_clkout;
   logic            r_oe;
   logic            r_busy;
   logic            r_tick;

   // div is captured only when a high phase starts, so every period is fully formed.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_nextDivq  = r_divq;
      w_terminal  = (r_cnt == r_divq);
      case (r_state)
         IDLE: begin
            w_nextCnt = '0;
            if (en) begin
               w_nextState = PRE;
            end
         end
         PRE: begin
            w_nextCnt = '0;
            if (en) begin
               w_nextState = HIGH;
               w_nextDivq  = div;
            end else begin
               w_nextState = IDLE;
            end
         end
         HIGH: begin
            if (w_terminal) begin
               w_nextState = LOW;
               w_nextCnt   = '0;
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         LOW: begin
            if (w_terminal) begin
               w_nextCnt = '0;
               if (en) begin
                  w_nextState = HIGH;
                  w_nextDivq  = div;
               end else begin
                  w_nextState = IDLE;
               end
            end else begin
               w_nextCnt = r_cnt + 1'b1;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      endcase
      w_enterHigh = (w_nextState == HIGH) && (r_state != HIGH);
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_divq   <= '0;
         r_clkout <= 1'b0;
         r_oe     <= 1'b0;
         r_busy   <= 1'b0;
         r_tick   <= 1'b0;
      end else begin
         r_state  <= w_nextState;
         r_cnt    <= w_nextCnt;
         r_divq   <= w_nextDivq;
         r_clkout <= (w_nextState == HIGH);
         r_oe     <= (w_nextState != IDLE);
         r_busy   <= (w_nextState != IDLE);
         r_tick   <= w_enterHigh;
      end
   end

   assign clkout = r_clkout;
   assign oe     = r_oe;
   assign busy   = r_busy;
   assign tick   = r_tick;

endmodule

// File: tb/tb_la_clkout.sv
// Scoreboard bench for la_clkout: per-cycle stimulus and expected {clkout,oe,busy,tick}
// are queued together, then replayed and compared one clock at a time.
module tb_la_clkout;

   typedef struct packed {
      logic       reset;
      logic       en;
      logic [7:0] div;
   } stim_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [7:0] div;
   logic       clkout;
   logic       oe;
   logic       busy;
   logic       tick;

   stim_t      stimQ[$];
   logic [3:0] expQ[$];
   int         testsRun    = 0;
   int         testsFailed = 0;

   localparam logic [3:0] E_IDLE  = 4'b0000;
   localparam logic [3:0] E_PRE   = 4'b0110;
   localparam logic [3:0] E_RISE  = 4'b1111;
   localparam logic [3:0] E_HIGH  = 4'b1110;
   localparam logic [3:0] E_LOW   = 4'b0110;

   la_clkout #(.DIVW(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .div    (div),
      .clkout (clkout),
      .oe     (oe),
      .busy   (busy),
      .tick   (tick)
   );

   always #5 clk = ~clk;

   task automatic pushCycle(input logic r, input logic e, input logic [7:0] d, input logic [3:0] x);
      stim_t s;
      s.reset = r;
      s.en    = e;
      s.div   = d;
      stimQ.push_back(s);
      expQ.push_back(x);
   endtask

   // One en=1 edge from IDLE: the pad enable rises one cycle ahead of the first edge.
   task automatic pushPre(input logic [7:0] d);
      pushCycle(1'b0, 1'b1, d, E_PRE);
   endtask

   // One full period of half-length d+1; en/div are only meaningful on the edge that
   // starts the high phase and on the final low edge, so elsewhere they can be noise.
   task automatic pushPeriod(input int d, input bit last, input bit noise);
      for (int i = 0; i <= d; i++) begin
         if (i == 0)
            pushCycle(1'b0, 1'b1, 8'(d), E_RISE);
         else
            pushCycle(1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b1, 8'($urandom_range(0, 255)), E_HIGH);
      end
      for (int i = 0; i <= d; i++)
         pushCycle(1'b0, noise ? 1'($urandom_range(0, 1)) : 1'b1, 8'($urandom_range(0, 255)), E_LOW);
      if (last)
         pushCycle(1'b0, 1'b0, 8'($urandom_range(0, 255)), E_IDLE);
   endtask

   task automatic test_reset();
      stim_t s;
      logic [3:0] e;
      int cyc = 0;
      pushCycle(1'b1, 1'b1, 8'd0, E_IDLE);
      pushCycle(1'b1, 1'b1, 8'd0, E_IDLE);
      while (stimQ.size() > 0) begin
         s = stimQ.pop_front();
         reset = s.reset; en = s.en; div = s.div;
         @(posedge clk); #1;
         e = expQ.pop_front();
         testsRun++;
         if ({clkout, oe, busy, tick} !== e) begin
            testsFailed++;
            $display("[TB] FAIL test_reset cycle %0d: got %b expected %b", cyc, {clkout, oe, busy, tick}, e);
         end
         cyc++;
      end
   endtask

   task automatic test_div0();
      stim_t s;
      logic [3:0] e;
      int cyc = 0;
      pushPre(8'd0);
      for (int p = 0; p < 5; p++) pushPeriod(0, p == 4, 1'b0);
      while (stimQ.size() > 0) begin
         s = stimQ.pop_front();
         reset = s.reset; en = s.en; div = s.div;
         @(posedge clk); #1;
         e = expQ.pop_front();
         testsRun++;
         if ({clkout, oe, busy, tick} !== e) begin
            testsFailed++;
            $display("[TB] FAIL test_div0 cycle %0d: got %b expected %b", cyc, {clkout, oe, busy, tick}, e);
         end
         cyc++;
      end
   endtask

   task automatic test_stop_div3();
      stim_t s;
      logic [3:0] e;
      int cyc = 0;
      pushPre(8'd3);
      for (int p = 0; p < 3; p++) pushPeriod(3, p == 2, 1'b1);
      while (stimQ.size() > 0) begin
         s = stimQ.pop_front();
         reset = s.reset; en = s.en; div = s.div;
         @(posedge clk); #1;
         e = expQ.pop_front();
         testsRun++;
         if ({clkout, oe, busy, tick} !== e) begin
            testsFailed++;
            $display("[TB] FAIL test_stop_div3 cycle %0d: got %b expected %b", cyc, {clkout, oe, busy, tick}, e);
         end
         cyc++;
      end
   endtask

   task automatic test_div_change();
      stim_t s;
      logic [3:0] e;
      int cyc = 0;
      pushPre(8'd2);
      pushPeriod(2, 1'b0, 1'b0);
      pushPeriod(5, 1'b0, 1'b1);
      pushPeriod(1, 1'b1, 1'b1);
      while (stimQ.size() > 0) begin
         s = stimQ.pop_front();
         reset = s.reset; en = s.en; div = s.div;
         @(posedge clk); #1;
         e = expQ.pop_front();
         testsRun++;
         if ({clkout, oe, busy, tick} !== e) begin
            testsFailed++;
            $display("[TB] FAIL test_div_change cycle %0d: got %b expected %b", cyc, {clkout, oe, busy, tick}, e);
         end
         cyc++;
      end
   endtask

   task automatic test_en_glitch();
      stim_t s;
      logic [3:0] e;
      int cyc = 0;
      pushCycle(1'b0, 1'b1, 8'd7, E_PRE);
      pushCycle(1'b0, 1'b0, 8'd7, E_IDLE);
      pushCycle(1'b0, 1'b0, 8'd7, E_IDLE);
      pushCycle(1'b0, 1'b0, 8'd7, E_IDLE);
      while (stimQ.size() > 0) begin
         s = stimQ.pop_front();
         reset = s.reset; en = s.en; div = s.div;
         @(posedge clk); #1;
         e = expQ.pop_front();
         testsRun++;
         if ({clkout, oe, busy, tick} !== e) begin
            testsFailed++;
            $display("[TB] FAIL test_en_glitch cycle %0d: got %b expected %b", cyc, {clkout, oe, busy, tick}, e);
         end
         cyc++;
      end
   endtask

   task automatic test_reset_mid_period();
      stim_t s;
      logic [3:0] e;
      int cyc = 0;
      pushPre(8'd4);
      pushCycle(1'b0, 1'b1, 8'd4, E_RISE);
      pushCycle(1'b0, 1'b1, 8'd4, E_HIGH);
      pushCycle(1'b1, 1'b1, 8'd4, E_IDLE);
      pushPre(8'd4);
      pushPeriod(4, 1'b1, 1'b0);
      while (stimQ.size() > 0) begin
         s = stimQ.pop_front();
         reset = s.reset; en = s.en; div = s.div;
         @(posedge clk); #1;
         e = expQ.pop_front();
         testsRun++;
         if ({clkout, oe, busy, tick} !== e) begin
            testsFailed++;
            $display("[TB] FAIL test_reset_mid_period cycle %0d: got %b expected %b", cyc, {clkout, oe, busy, tick}, e);
         end
         cyc++;
      end
   endtask

   task automatic test_max_div();
      stim_t s;
      logic [3:0] e;
      int cyc = 0;
      int highCount = 0;
      int tickCount = 0;
      pushPre(8'd255);
      for (int p = 0; p < 3; p++) pushPeriod(255, p == 2, 1'b0);
      while (stimQ.size() > 0) begin
         s = stimQ.pop_front();
         reset = s.reset; en = s.en; div = s.div;
         @(posedge clk); #1;
         e = expQ.pop_front();
         if (clkout === 1'b1) highCount++;
         if (tick === 1'b1) tickCount++;
         testsRun++;
         if ({clkout, oe, busy, tick} !== e) begin
            testsFailed++;
            $display("[TB] FAIL test_max_div cycle %0d: got %b expected %b", cyc, {clkout, oe, busy, tick}, e);
         end
         cyc++;
      end
      testsRun++;
      if (highCount !== 3 * 256) begin
         testsFailed++;
         $display("[TB] FAIL test_max_div high cycles: got %0d expected %0d", highCount, 3 * 256);
      end
      testsRun++;
      if (tickCount !== 3) begin
         testsFailed++;
         $display("[TB] FAIL test_max_div ticks: got %0d expected %0d", tickCount, 3);
      end
   endtask

   initial begin
      reset = 1'b1;
      en    = 1'b0;
      div   = 8'd0;
      test_reset();
      test_div0();
      test_stop_div3();
      test_div_change();
      test_en_glitch();
      test_reset_mid_period();
      test_max_div();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
